// File: rtl/madd_eval_pkg.sv
// Shared types and constants for the multiply-add error evaluation blocks.
package madd_eval_pkg;

  localparam int unsigned MaddInW  = 18;
  localparam int unsigned MaddOutW = 12;

  // Supported result latency of the netlist pair.
  localparam int unsigned LatMin = 1;
  localparam int unsigned LatMax = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sweep_state_e;

endpackage

// File: rtl/err_accum.sv
// Error metric accumulator: |exact-approx|, error count, sum, and first worst-case vector.
module err_accum
  import madd_eval_pkg::*;
#(
  parameter int unsigned IN_W  = MaddInW,
  parameter int unsigned OUT_W = MaddOutW,
  parameter int unsigned CNT_W = IN_W + 1,
  parameter int unsigned SUM_W = IN_W + OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [IN_W-1:0]  tag_i,
  input  logic [OUT_W-1:0] exact_i,
  input  logic [OUT_W-1:0] approx_i,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [SUM_W-1:0] sum_abs_o,
  output logic [OUT_W-1:0] max_abs_o,
  output logic [IN_W-1:0]  worst_vec_o
);

  logic [OUT_W-1:0] w_diff;
  logic [CNT_W-1:0] r_err_cnt;
  logic [SUM_W-1:0] r_sum_abs;
  logic [OUT_W-1:0] r_max_abs;
  logic [IN_W-1:0]  r_worst_vec;

  assign w_diff = (exact_i >= approx_i) ? (exact_i - approx_i) : (approx_i - exact_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt   <= '0;
      r_sum_abs   <= '0;
      r_max_abs   <= '0;
      r_worst_vec <= '0;
    end else if (clear_i) begin
      r_err_cnt   <= '0;
      r_sum_abs   <= '0;
      r_max_abs   <= '0;
      r_worst_vec <= '0;
    end else if (valid_i) begin
      if (w_diff != '0) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      r_sum_abs <= r_sum_abs + SUM_W'(w_diff);
      // Strict compare so ties keep the earliest vector.
      if (w_diff > r_max_abs) begin
        r_max_abs   <= w_diff;
        r_worst_vec <= tag_i;
      end
    end
  end

  assign err_cnt_o   = r_err_cnt;
  assign sum_abs_o   = r_sum_abs;
  assign max_abs_o   = r_max_abs;
  assign worst_vec_o = r_worst_vec;

endmodule

// File: rtl/madd_err_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives every input vector, aligns results over LAT cycles and
// accumulates exact-vs-approximate error statistics.
module madd_err_sweep_ctrl
  import madd_eval_pkg::*;
#(
  parameter int unsigned IN_W  = MaddInW,
  parameter int unsigned OUT_W = MaddOutW,
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = IN_W + 1,
  parameter int unsigned SUM_W = IN_W + OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [IN_W-1:0]  vec_o,
  input  logic [OUT_W-1:0] exact_i,
  input  logic [OUT_W-1:0] approx_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [SUM_W-1:0] sum_abs_o,
  output logic [OUT_W-1:0] max_abs_o,
  output logic [IN_W-1:0]  worst_vec_o
);

  localparam int unsigned DrnW = $clog2(LatMax);

  sweep_state_e    r_state, w_state_nxt;
  logic [IN_W-1:0] r_vec, w_vec_nxt;
  logic [DrnW-1:0] r_drain, w_drain_nxt;
  logic [LAT-1:0]  r_vld;
  logic [IN_W-1:0] r_tag [LAT];
  logic            w_clear;
  logic            w_run;
  logic            w_acc_vld;

  assign w_run = (r_state == StRun);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_vec   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_drain_nxt = r_drain;
    w_clear     = 1'b0;
    if (abort_i) begin
      w_state_nxt = StIdle;
      w_vec_nxt   = '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start_i) begin
            w_state_nxt = StRun;
            w_vec_nxt   = '0;
            w_clear     = 1'b1;
          end
        end
        StRun: begin
          // Wraps to 0 after the all-ones vector; the wrapped value is never tagged valid.
          w_vec_nxt = r_vec + IN_W'(1);
          if (r_vec == '1) begin
            w_state_nxt = StDrain;
            w_drain_nxt = '0;
          end
        end
        StDrain: begin
          if (r_drain == DrnW'(LAT - 1)) begin
            w_state_nxt = StDone;
          end else begin
            w_drain_nxt = r_drain + DrnW'(1);
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_run & ~abort_i;
      r_tag[0] <= r_vec;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1] & ~abort_i;
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // The result arriving on the abort edge is discarded along with the rest of the pipeline.
  assign w_acc_vld = r_vld[LAT-1] & ~abort_i;

  err_accum #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_err_accum (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (w_clear),
    .valid_i     (w_acc_vld),
    .tag_i       (r_tag[LAT-1]),
    .exact_i     (exact_i),
    .approx_i    (approx_i),
    .err_cnt_o   (err_cnt_o),
    .sum_abs_o   (sum_abs_o),
    .max_abs_o   (max_abs_o),
    .worst_vec_o (worst_vec_o)
  );

  assign vec_o  = r_vec;
  assign busy_o = (r_state == StRun) || (r_state == StDrain);
  assign done_o = (r_state == StDone);

endmodule

// File: tb/tb_madd_err_sweep_ctrl.sv
// Self-checking bench: three sweep controllers (LAT 1 and 3 at 4 bits, LAT 2 at 12 bits) fed
// by table-driven netlist models and checked against a per-vector error model.
module tb_madd_err_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int ex_t [3][4096];
  int ap_t [3][4096];
  int n_vec [3] = '{16, 16, 4096};
  int lat_k [3] = '{1, 3, 2};

  // DUT A: IN_W=4, OUT_W=4, LAT=1
  logic a_start = 1'b0, a_abort = 1'b0, a_busy, a_done;
  logic [3:0] a_vec, a_ex, a_ap, a_max, a_wv;
  logic [4:0] a_cnt;
  logic [7:0] a_sum;
  // DUT B: IN_W=4, OUT_W=4, LAT=3
  logic b_start = 1'b0, b_abort = 1'b0, b_busy, b_done;
  logic [3:0] b_vec, b_ex, b_ap, b_max, b_wv;
  logic [4:0] b_cnt;
  logic [7:0] b_sum;
  // DUT C: IN_W=12, OUT_W=12, LAT=2
  logic c_start = 1'b0, c_abort = 1'b0, c_busy, c_done;
  logic [11:0] c_vec, c_ex, c_ap, c_max, c_wv;
  logic [12:0] c_cnt;
  logic [23:0] c_sum;

  madd_err_sweep_ctrl #(.IN_W(4), .OUT_W(4), .LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .abort_i(a_abort), .vec_o(a_vec),
    .exact_i(a_ex), .approx_i(a_ap), .busy_o(a_busy), .done_o(a_done), .err_cnt_o(a_cnt),
    .sum_abs_o(a_sum), .max_abs_o(a_max), .worst_vec_o(a_wv)
  );
  madd_err_sweep_ctrl #(.IN_W(4), .OUT_W(4), .LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .abort_i(b_abort), .vec_o(b_vec),
    .exact_i(b_ex), .approx_i(b_ap), .busy_o(b_busy), .done_o(b_done), .err_cnt_o(b_cnt),
    .sum_abs_o(b_sum), .max_abs_o(b_max), .worst_vec_o(b_wv)
  );
  madd_err_sweep_ctrl #(.IN_W(12), .OUT_W(12), .LAT(2)) u_dut_c (
    .clk(clk), .rst(rst), .start_i(c_start), .abort_i(c_abort), .vec_o(c_vec),
    .exact_i(c_ex), .approx_i(c_ap), .busy_o(c_busy), .done_o(c_done), .err_cnt_o(c_cnt),
    .sum_abs_o(c_sum), .max_abs_o(c_max), .worst_vec_o(c_wv)
  );

  // Netlist pair models: table lookup of the vector presented LAT cycles earlier.
  logic [3:0]  a_d0, b_d0, b_d1, b_d2;
  logic [11:0] c_d0, c_d1;
  always @(posedge clk) begin
    a_d0 <= a_vec;
    b_d0 <= b_vec;
    b_d1 <= b_d0;
    b_d2 <= b_d1;
    c_d0 <= c_vec;
    c_d1 <= c_d0;
  end
  assign a_ex = 4'(ex_t[0][a_d0]);
  assign a_ap = 4'(ap_t[0][a_d0]);
  assign b_ex = 4'(ex_t[1][b_d2]);
  assign b_ap = 4'(ap_t[1][b_d2]);
  assign c_ex = 12'(ex_t[2][c_d1]);
  assign c_ap = 12'(ap_t[2][c_d1]);

  task automatic set_in(input int k, input bit st, input bit ab);
    case (k)
      0: begin a_start = st; a_abort = ab; end
      1: begin b_start = st; b_abort = ab; end
      default: begin c_start = st; c_abort = ab; end
    endcase
  endtask

  task automatic get_m(input int k, output int vec, output int cnt, output int sum,
                       output int mx, output int wv, output bit bsy, output bit dn);
    case (k)
      0: begin
        vec = int'(a_vec); cnt = int'(a_cnt); sum = int'(a_sum); mx = int'(a_max);
        wv = int'(a_wv); bsy = a_busy; dn = a_done;
      end
      1: begin
        vec = int'(b_vec); cnt = int'(b_cnt); sum = int'(b_sum); mx = int'(b_max);
        wv = int'(b_wv); bsy = b_busy; dn = b_done;
      end
      default: begin
        vec = int'(c_vec); cnt = int'(c_cnt); sum = int'(c_sum); mx = int'(c_max);
        wv = int'(c_wv); bsy = c_busy; dn = c_done;
      end
    endcase
  endtask

  // Reference: metrics over vectors 0..last in sweep order.
  task automatic model(input int k, input int last, output int cnt, output int sum,
                       output int mx, output int wv);
    int d;
    cnt = 0; sum = 0; mx = 0; wv = 0;
    for (int v = 0; v <= last; v++) begin
      d = ex_t[k][v] - ap_t[k][v];
      if (d < 0) d = -d;
      if (d != 0) cnt++;
      sum += d;
      if (d > mx) begin
        mx = d;
        wv = v;
      end
    end
  endtask

  task automatic fill_random(input int k, input int pct);
    for (int v = 0; v < n_vec[k]; v++) begin
      ex_t[k][v] = int'($urandom_range(0, 15));
      ap_t[k][v] = ($urandom_range(0, 99) < pct) ? int'($urandom_range(0, 15)) : ex_t[k][v];
    end
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    set_in(k, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    set_in(k, 1'b0, 1'b0);
  endtask

  // Called #1 after a clock edge at cycle cyc0 (cycle 1 = first RUN cycle).
  task automatic wait_done(input int k, input int cyc0, output int done_cyc);
    int vec, c, s, m, w;
    bit bsy, dn, seq_bad;
    seq_bad  = 1'b0;
    done_cyc = -1;
    for (int cyc = cyc0; cyc <= n_vec[k] + lat_k[k] + 20; cyc++) begin
      get_m(k, vec, c, s, m, w, bsy, dn);
      if (dn) begin
        done_cyc = cyc;
        break;
      end
      if (cyc <= n_vec[k] && (vec != cyc - 1 || !bsy)) seq_bad = 1'b1;
      @(posedge clk);
      #1;
    end
    total++;
    if (done_cyc < 0 || seq_bad) begin
      bad++;
      $display("FAIL sweep_progress dut=%0d: done_cycle=%0d vec_seq_error=%0d, want done and no seq error",
               k, done_cyc, seq_bad);
    end
  endtask

  task automatic run_sweep(input int k, output int done_cyc);
    pulse_start(k);
    wait_done(k, 1, done_cyc);
  endtask

  task automatic test_reset();
    int vec, c, s, m, w;
    bit bsy, dn;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      get_m(k, vec, c, s, m, w, bsy, dn);
      total++;
      if ({vec, c, s, m, w, 30'(bsy), 2'(dn)} !== '0) begin
        bad++;
        $display("FAIL reset_state dut=%0d: vec=%0d cnt=%0d sum=%0d max=%0d worst=%0d busy=%0d done=%0d, want all 0",
                 k, vec, c, s, m, w, bsy, dn);
      end
    end
  endtask

  task automatic check_metrics(input string name, input int k, input int last);
    // Compares DUT metrics to the model; called only where a sweep or abort has completed.
    int vec, c, s, m, w, ec, es, em, ew;
    bit bsy, dn;
    model(k, last, ec, es, em, ew);
    get_m(k, vec, c, s, m, w, bsy, dn);
    total++;
    if ({c, s, m, w} !== {ec, es, em, ew}) begin
      bad++;
      $display("FAIL %s: got cnt=%0d sum=%0d max=%0d worst=%0d, want cnt=%0d sum=%0d max=%0d worst=%0d",
               name, c, s, m, w, ec, es, em, ew);
    end
  endtask

  task automatic test_clean();
    int dc;
    for (int v = 0; v < 16; v++) begin
      ex_t[0][v] = int'($urandom_range(0, 15));
      ap_t[0][v] = ex_t[0][v];
    end
    run_sweep(0, dc);
    total++;
    if (dc !== 18) begin
      bad++;
      $display("FAIL clean_done_cycle: got %0d, want 18", dc);
    end
    total++;
    if ({a_cnt, a_sum, a_max, a_wv} !== '0) begin
      bad++;
      $display("FAIL clean_metrics: got cnt=%0d sum=%0d max=%0d worst=%0d, want all 0",
               a_cnt, a_sum, a_max, a_wv);
    end
  endtask

  task automatic test_two_errors();
    int dc;
    for (int v = 0; v < 16; v++) begin
      ex_t[0][v] = int'($urandom_range(3, 14));
      ap_t[0][v] = ex_t[0][v];
    end
    ap_t[0][5] = ex_t[0][5] + 1;
    ap_t[0][9] = ex_t[0][9] - 3;
    run_sweep(0, dc);
    total++;
    if ({a_cnt, a_sum, a_max, a_wv} !== {5'd2, 8'd4, 4'd3, 4'd9}) begin
      bad++;
      $display("FAIL two_errors: got cnt=%0d sum=%0d max=%0d worst=%0d, want 2 4 3 9",
               a_cnt, a_sum, a_max, a_wv);
    end
  endtask

  task automatic test_random_sweeps();
    int dc;
    for (int r = 0; r < 3; r++) begin
      fill_random(0, 40 + 25 * r);
      run_sweep(0, dc);
      check_metrics("random_sweep", 0, 15);
    end
  endtask

  task automatic test_tie_lat3();
    int dc;
    for (int v = 0; v < 16; v++) begin
      ex_t[1][v] = int'($urandom_range(0, 8));
      ap_t[1][v] = ex_t[1][v] + int'($urandom_range(0, 6));
    end
    ap_t[1][3]  = ex_t[1][3] + 7;
    ap_t[1][12] = ex_t[1][12] + 7;
    run_sweep(1, dc);
    total++;
    if (dc !== 20) begin
      bad++;
      $display("FAIL tie_done_cycle: got %0d, want 20", dc);
    end
    total++;
    if ({b_max, b_wv} !== {4'd7, 4'd3}) begin
      bad++;
      $display("FAIL tie_worst: got max=%0d worst=%0d, want max=7 worst=3", b_max, b_wv);
    end
    check_metrics("tie_metrics", 1, 15);
  endtask

  task automatic test_abort();
    int dc;
    bit seen, done_seen;
    fill_random(0, 60);
    pulse_start(0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (a_vec == 4'd6 && a_busy) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    set_in(0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0);
    total++;
    if (!seen || a_busy !== 1'b0 || a_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: reached_vec6=%0d busy=%0d done=%0d, want 1 0 0",
               seen, a_busy, a_done);
    end
    // Vec 6 seen in cycle 7 with LAT=1: only vectors 0..4 had results before the abort edge.
    check_metrics("abort_partial", 0, 4);
    done_seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (a_done || a_busy) done_seen = 1'b1;
    end
    total++;
    if (done_seen) begin
      bad++;
      $display("FAIL abort_stays_idle: got busy/done activity=1, want 0");
    end
    pulse_start(0);
    total++;
    if ({a_cnt, a_sum, a_max, a_wv, a_vec} !== '0 || a_busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_clear: cnt=%0d sum=%0d max=%0d worst=%0d vec=%0d busy=%0d, want 0s busy=1",
               a_cnt, a_sum, a_max, a_wv, a_vec, a_busy);
    end
    wait_done(0, 1, dc);
    check_metrics("restart_full", 0, 15);
  endtask

  task automatic test_start_ignored_and_reset();
    int dc;
    fill_random(0, 50);
    pulse_start(0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    set_in(0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0);
    wait_done(0, 6, dc);
    total++;
    if (dc !== 18) begin
      bad++;
      $display("FAIL start_in_run_ignored: done cycle %0d, want 18", dc);
    end
    check_metrics("start_ignored_metrics", 0, 15);
    run_sweep(0, dc);
    check_metrics("rerun_from_done", 0, 15);
    // Walk into DRAIN (cycle 17 for LAT=1), then hit reset between edges.
    pulse_start(0);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (a_busy !== 1'b1 || a_vec !== 4'd0) begin
      bad++;
      $display("FAIL drain_entry: busy=%0d vec=%0d, want busy=1 vec=0", a_busy, a_vec);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({a_vec, a_cnt, a_sum, a_max, a_wv, a_busy, a_done} !== '0) begin
      bad++;
      $display("FAIL async_reset_drain: vec=%0d cnt=%0d sum=%0d max=%0d worst=%0d busy=%0d done=%0d, want 0",
               a_vec, a_cnt, a_sum, a_max, a_wv, a_busy, a_done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_abort_in_done_idle();
    int dc;
    fill_random(0, 70);
    run_sweep(0, dc);
    @(negedge clk);
    set_in(0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0);
    total++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_from_done: done=%0d busy=%0d, want 0 0", a_done, a_busy);
    end
    check_metrics("abort_done_retained", 0, 15);
    // Abort wins over a simultaneous start.
    @(negedge clk);
    set_in(0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0);
    total++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_over_start: busy=%0d done=%0d, want 0 0", a_busy, a_done);
    end
    check_metrics("abort_start_retained", 0, 15);
  endtask

  task automatic test_madd_sweep();
    int dc, e;
    for (int v = 0; v < 4096; v++) begin
      e = (v >> 8) * ((v >> 4) & 15) + (v & 15);
      ex_t[2][v] = e;
      ap_t[2][v] = (e & ~3) | int'($urandom_range(0, 3));
    end
    run_sweep(2, dc);
    total++;
    if (dc !== 4096 + 2 + 1) begin
      bad++;
      $display("FAIL madd_done_cycle: got %0d, want %0d", dc, 4096 + 2 + 1);
    end
    check_metrics("madd_metrics", 2, 4095);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_two_errors();
    test_random_sweeps();
    test_tie_lat3();
    test_abort();
    test_start_ignored_and_reset();
    test_abort_in_done_idle();
    test_madd_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/madd_err_sweep_ctrl.md
Name: madd_err_sweep_ctrl

Overview:
- Sequencer that exhaustively sweeps every input vector through an exact and an approximate multiply-add netlist instantiated side by side.
- Compares the two results each cycle and accumulates error statistics: error count, sum of absolute error, maximum absolute error, and the vector that first produced it.
- Sits between the testbench/host register interface and the DUT netlist pair; it owns sweep sequencing, result alignment and metric accumulation.

Parameters:
- IN_W, 18, total DUT input width; the sweep covers 0 .. 2^IN_W-1.
- OUT_W, 12, DUT output width; exact and approximate results are unsigned.
- LAT, 1, cycles from vec_o to the matching results on exact_i/approx_i; legal range 1..4.
- CNT_W, IN_W+1, width of the error counter.
- SUM_W, IN_W+OUT_W, width of the absolute-error sum; cannot overflow.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  pulse; starts a sweep from IDLE or DONE.
- abort_i  in  1  pulse; terminates a sweep in progress.
- vec_o  out  IN_W  input vector driven to both netlists.
- exact_i  in  OUT_W  exact netlist result.
- approx_i  in  OUT_W  approximate netlist result.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  high in DONE.
- err_cnt_o  out  CNT_W  number of vectors with exact != approx.
- sum_abs_o  out  SUM_W  sum of |exact-approx|.
- max_abs_o  out  OUT_W  maximum |exact-approx|.
- worst_vec_o  out  IN_W  first vector reaching max_abs_o.

Behaviour:
- Reset: state IDLE; vec_o=0, busy_o=0, done_o=0, all metrics 0, valid pipeline cleared.
- States:
  - IDLE: start_i -> clear metrics, vec_o=0, go to RUN.
  - RUN: one vector per cycle; vec_o increments each cycle. The cycle that presents 2^IN_W-1 is the last RUN cycle; next state DRAIN. vec_o wraps to 0 and the wrapped value is not tagged valid.
  - DRAIN: LAT cycles of waiting; no new valid vectors. Then go to DONE.
  - DONE: metrics and done_o held. start_i -> clear metrics, go to RUN.
- Start is sampled at a clock edge. vec 0 is presented the next cycle, and vec n is presented n cycles after that.
- Alignment:
  - A LAT-deep shift register carries a valid bit and the vector tag.
  - Results in cycle t belong to the vector presented in cycle t-LAT.
  - Accumulation happens only when the delayed valid bit is 1.
- Metrics, per valid result:
  - d = |exact_i - approx_i|, unsigned, OUT_W bits.
  - If d != 0, err_cnt increments.
  - sum_abs += d.
  - If d > max_abs (strict), update max_abs and worst_vec to the tagged vector. Ties keep the earlier vector.
- Accumulation stops at the last valid result; later inputs are ignored.
- Timing, IN_W=4, LAT=1, start high in cycle 0:
  - vec 0..15 in cycles 1..16.
  - Last result accumulated at the end of cycle 17.
  - done_o=1 from cycle 18.
  - Total sweep latency: 2^IN_W + LAT + 1 cycles from the start edge to done_o.
- Simultaneous events:
  - abort_i has priority over start_i in every state.
  - abort_i in RUN or DRAIN -> IDLE next cycle: valid pipeline flushed, metrics frozen at partial values, done_o stays 0.
  - abort_i in IDLE or DONE -> IDLE, metrics retained.
  - start_i in RUN or DRAIN is ignored.
- Reset mid-sweep: immediate return to reset values regardless of state.
- Metrics are visible live during RUN/DRAIN and are final only while done_o=1.

Decomposition:
- Shared package madd_eval_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - default IN_W/OUT_W constants for the madd family;
  - the localparam for the LAT bound.
- Sub-module err_accum:
  - absolute difference, compare-and-update of max/worst tag, counter and sum registers;
  - inputs: clear, valid, tag, exact, approx.
- Top level holds the FSM, vector counter and the valid/tag delay line.

Test Plan (IN_W=4, OUT_W=4 unless stated):
1. Bench model sets approx=exact for all vectors, LAT=1, start in cycle 0 -> done_o from cycle 18; err_cnt=0, sum=0, max=0, worst_vec=0.
2. approx=exact+1 only for vec 5, approx=exact-3 only for vec 9 -> err_cnt=2, sum=4, max=3, worst_vec=9.
3. Two vectors both with d=7 (vec 3 and vec 12), LAT=3 -> max=7, worst_vec=3 (tie keeps first); done_o exactly 2^4+3+1=20 cycles after the start edge.
4. abort_i asserted while vec_o=6 -> IDLE next cycle, busy_o=0, done_o never rises; metrics reflect only the results accumulated before the abort edge; a subsequent start clears the metrics and re-sweeps from 0.
5. start_i pulsed during RUN is ignored (count unchanged); rst asserted during DRAIN -> all outputs 0 asynchronously; start_i from DONE re-runs and gives identical metrics.
6. Full size IN_W=18, OUT_W=12, exact = a*b+c reference against a bench-injected approximation -> sum_abs_o matches the golden software total, no overflow, done_o after 2^18+LAT+1 cycles.
